// File: rtl/bullet_pkg.sv
// bullet_pkg: shared direction encodings, screen extents and coordinate widths for the bullet pool.
package bullet_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_POS = 2'b01;
  localparam logic [1:0] DIR_NEG = 2'b10;
endpackage

// File: rtl/bullet_slot.sv
// bullet_slot: one bullet's state; loads on spawn, clears on kill, moves or expires on tick.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int MAX_LIFE = 200,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           load,
  input  logic           kill,
  input  logic [X_W-1:0] ld_x,
  input  logic [Y_W-1:0] ld_y,
  input  logic [1:0]     ld_dx,
  input  logic [1:0]     ld_dy,
  output logic           active,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);
  localparam int LW = $clog2(MAX_LIFE + 1);
  logic [1:0] dx, dy;
  logic [LW-1:0] life;
  logic at_edge;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  // The edge test runs before stepping, so x/y never wrap.
  assign at_edge = (dx == DIR_NEG && x == '0) || (dx == DIR_POS && x == X_W'(SCR_W - 1)) ||
                   (dy == DIR_NEG && y == '0) || (dy == DIR_POS && y == Y_W'(SCR_H - 1));
  assign nx = dx == DIR_POS ? x + 1'b1 : dx == DIR_NEG ? x - 1'b1 : x;
  assign ny = dy == DIR_POS ? y + 1'b1 : dy == DIR_NEG ? y - 1'b1 : y;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      x <= '0;
      y <= '0;
      dx <= DIR_HOLD;
      dy <= DIR_HOLD;
      life <= '0;
    end else if (load) begin
      active <= 1'b1;
      x <= ld_x;
      y <= ld_y;
      dx <= ld_dx;
      dy <= ld_dy;
      life <= LW'(MAX_LIFE);
    end else if (kill) begin
      active <= 1'b0;
    end else if (tick && active) begin
      if (life == '0 || at_edge) begin
        active <= 1'b0;
      end else begin
        life <= life - 1'b1;
        x <= nx;
        y <= ny;
      end
    end
  end
endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: fixed pool of bullet slots with tick-based movement, lowest-free allocation,
// kill decode and a round-robin registered scan port.
module bullet_pool #(
  parameter int NUM_BULLETS = 8,
  parameter int TICK_PERIOD = 10,
  parameter int MAX_LIFE = 200,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int IDX_W = $clog2(NUM_BULLETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fire,
  input  logic [1:0]       dir_x,
  input  logic [1:0]       dir_y,
  input  logic [7:0]       ship_x,
  input  logic [6:0]       ship_y,
  input  logic             kill_valid,
  input  logic [IDX_W-1:0] kill_idx,
  output logic             fire_accept,
  output logic             pool_full,
  output logic [IDX_W:0]   active_count,
  output logic [IDX_W-1:0] scan_idx,
  output logic [7:0]       scan_x,
  output logic [6:0]       scan_y,
  output logic             scan_active
);
  import bullet_pkg::*;
  localparam int CW = $clog2(TICK_PERIOD);
  logic [CW-1:0] cnt;
  logic tick;
  logic [NUM_BULLETS-1:0] act, load, kill;
  logic [X_W-1:0] xs [NUM_BULLETS];
  logic [Y_W-1:0] ys [NUM_BULLETS];
  logic [IDX_W-1:0] sel, ptr;
  assign tick = cnt == CW'(TICK_PERIOD - 1);
  assign pool_full = &act;
  assign fire_accept = fire & ~pool_full;
  // Allocation looks only at registered flags, so a slot killed this cycle is not reused until next.
  always_comb begin
    sel = '0;
    active_count = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) if (!act[i]) sel = IDX_W'(i);
    for (int i = 0; i < NUM_BULLETS; i++) active_count = active_count + (IDX_W + 1)'(act[i]);
  end
  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    assign load[g] = fire_accept && sel == IDX_W'(g);
    assign kill[g] = kill_valid && kill_idx == IDX_W'(g);
    bullet_slot #(.MAX_LIFE(MAX_LIFE), .SCR_W(SCREEN_W), .SCR_H(SCREEN_H)) u_slot (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .load(load[g]),
      .kill(kill[g]),
      .ld_x(ship_x),
      .ld_y(ship_y),
      .ld_dx(dir_x),
      .ld_dy(dir_y),
      .active(act[g]),
      .x(xs[g]),
      .y(ys[g])
    );
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ptr <= '0;
      scan_idx <= '0;
      scan_x <= '0;
      scan_y <= '0;
      scan_active <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      ptr <= ptr == IDX_W'(NUM_BULLETS - 1) ? '0 : ptr + 1'b1;
      scan_idx <= ptr;
      scan_x <= xs[ptr];
      scan_y <= ys[ptr];
      scan_active <= act[ptr];
    end
  end
endmodule
